// File: rtl/sort_seq_pkg.sv
// Shared encodings for the bubble-sort control sequencer: FSM states and
// register-file write-source selects.
package sort_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMP      = 4'd1,
    ST_EVAL     = 4'd2,
    ST_SW1      = 4'd3,
    ST_SW2      = 4'd4,
    ST_SW3      = 4'd5,
    ST_ADV      = 4'd6,
    ST_PASS_END = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  localparam logic [1:0] WSRC_A   = 2'b00;
  localparam logic [1:0] WSRC_B   = 2'b01;
  localparam logic [1:0] WSRC_TMP = 2'b10;

endpackage

// File: rtl/sort_sequencer.sv
// Control FSM that bubble-sorts N_ELEM datapath registers into ascending order.
// Optional swap counter output o_swap_cnt is built when SORT_SWAP_CNT_EN is defined.
module sort_sequencer
  import sort_seq_pkg::*;
#(
  parameter int N_ELEM = 4,
  parameter int IDX_W  = 2
`ifdef SORT_SWAP_CNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gt,
  output logic [IDX_W-1:0] sel_a,
  output logic [IDX_W-1:0] sel_b,
  output logic [IDX_W-1:0] sel_w,
  output logic [1:0]       wsrc,
  output logic             we,
  output logic             tmp_we,
  output logic             busy,
  output logic             done
`ifdef SORT_SWAP_CNT_EN
  ,
  output logic [CNT_W-1:0] o_swap_cnt
`endif
);

  localparam logic [IDX_W-1:0] LIMIT_INIT = IDX_W'(N_ELEM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_limit;
  logic             r_swapped;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_i_nxt;
  logic [IDX_W-1:0] w_limit_nxt;
  logic             w_swapped_nxt;
  logic [IDX_W-1:0] w_i_plus1;

  assign w_i_plus1 = r_i + IDX_ONE;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_limit   <= LIMIT_INIT;
      r_swapped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_limit   <= w_limit_nxt;
      r_swapped <= w_swapped_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_i_nxt       = r_i;
    w_limit_nxt   = r_limit;
    w_swapped_nxt = r_swapped;
    sel_a         = '0;
    sel_b         = '0;
    sel_w         = '0;
    wsrc          = WSRC_A;
    we            = 1'b0;
    tmp_we        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_CMP;
          w_i_nxt       = '0;
          w_limit_nxt   = LIMIT_INIT;
          w_swapped_nxt = 1'b0;
        end
      end
      ST_CMP: begin
        busy        = 1'b1;
        sel_a       = r_i;
        sel_b       = w_i_plus1;
        w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        busy        = 1'b1;
        sel_a       = r_i;
        sel_b       = w_i_plus1;
        w_state_nxt = gt ? ST_SW1 : ST_ADV;
      end
      ST_SW1: begin
        busy        = 1'b1;
        sel_a       = r_i;
        sel_b       = w_i_plus1;
        tmp_we      = 1'b1;
        w_state_nxt = ST_SW2;
      end
      ST_SW2: begin
        busy        = 1'b1;
        sel_a       = r_i;
        sel_b       = w_i_plus1;
        we          = 1'b1;
        sel_w       = r_i;
        wsrc        = WSRC_B;
        w_state_nxt = ST_SW3;
      end
      ST_SW3: begin
        busy          = 1'b1;
        sel_a         = r_i;
        sel_b         = w_i_plus1;
        we            = 1'b1;
        sel_w         = w_i_plus1;
        wsrc          = WSRC_TMP;
        w_swapped_nxt = 1'b1;
        w_state_nxt   = ST_ADV;
      end
      ST_ADV: begin
        busy = 1'b1;
        if (r_i == r_limit - IDX_ONE) begin
          w_state_nxt = ST_PASS_END;
        end else begin
          w_i_nxt     = w_i_plus1;
          w_state_nxt = ST_CMP;
        end
      end
      ST_PASS_END: begin
        busy = 1'b1;
        // A swap-free pass means the remaining prefix is already ordered.
        if (!r_swapped || r_limit == IDX_ONE) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_limit_nxt   = r_limit - IDX_ONE;
          w_i_nxt       = '0;
          w_swapped_nxt = 1'b0;
          w_state_nxt   = ST_CMP;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides every transition; a half-done swap stays in the registers.
    if (abort) begin
      w_state_nxt   = ST_IDLE;
      w_i_nxt       = '0;
      w_limit_nxt   = LIMIT_INIT;
      w_swapped_nxt = 1'b0;
    end
  end

`ifdef SORT_SWAP_CNT_EN
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] r_swap_cnt;

  assign w_cnt_clr = (r_state == ST_IDLE) && start && !abort;
  // The SW3 write completes even when aborted, so that swap is still counted.
  assign w_cnt_inc = (r_state == ST_SW3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swap_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_swap_cnt <= '0;
    end else if (w_cnt_inc && (r_swap_cnt != '1)) begin
      r_swap_cnt <= r_swap_cnt + CNT_W'(1);
    end
  end

  assign o_swap_cnt = r_swap_cnt;
`endif

endmodule
